// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: ALU opcodes, ALUOp encodings
// and R-type funct codes.
package alu_issue_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ILL   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

endpackage

// File: rtl/alu_fwd_mux.sv
// Operand forwarding select: r0 reads zero, EX/MEM beats MEM/WB,
// otherwise register-file data.
module alu_fwd_mux
    import alu_issue_stage_pkg::*;
#(
    parameter int W  = 16,
    parameter int RA = 3
) (
    input  logic [RA-1:0] i_src,
    input  logic [W-1:0]  i_rf_data,
    input  logic          i_mem_we,
    input  logic [RA-1:0] i_mem_rd,
    input  logic [W-1:0]  i_mem_data,
    input  logic          i_wb_we,
    input  logic [RA-1:0] i_wb_rd,
    input  logic [W-1:0]  i_wb_data,
    output logic [W-1:0]  o_fwd
);

    always_comb begin
        o_fwd = i_rf_data;
        if (i_src == '0)
            o_fwd = '0;
        else if (i_mem_we && (i_mem_rd == i_src))
            o_fwd = i_mem_data;
        else if (i_wb_we && (i_wb_rd == i_src))
            o_fwd = i_wb_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: opcode translation, operand forwarding,
// valid/ready flow control, flush and a saturating stall counter.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int W     = 16,
    parameter int RA    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic             id_alusrc,
    input  logic [RA-1:0]    id_rs,
    input  logic [RA-1:0]    id_rt,
    input  logic [RA-1:0]    id_rd,
    input  logic [W-1:0]     id_rs_data,
    input  logic [W-1:0]     id_rt_data,
    input  logic [W-1:0]     id_imm,
    input  logic             mem_we,
    input  logic [RA-1:0]    mem_rd,
    input  logic [W-1:0]     mem_data,
    input  logic             wb_we,
    input  logic [RA-1:0]    wb_rd,
    input  logic [W-1:0]     wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    output logic             alu_cin,
    output logic [3:0]       alu_opcode,
    output logic [RA-1:0]    ex_rd,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_valid;
    logic [W-1:0]     r_x;
    logic [W-1:0]     r_y;
    logic             r_cin;
    logic [3:0]       r_op;
    logic [RA-1:0]    r_rd;
    logic             r_ill;
    logic [CNT_W-1:0] r_stall;

    logic [W-1:0]     w_x;
    logic [W-1:0]     w_rt_fwd;
    logic [W-1:0]     w_y;
    logic [3:0]       w_opcode;
    logic             w_illegal;
    logic             w_load;

    alu_fwd_mux #(.W(W), .RA(RA)) u_fwd_x (
        .i_src      (id_rs),
        .i_rf_data  (id_rs_data),
        .i_mem_we   (mem_we),
        .i_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .i_wb_we    (wb_we),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_fwd      (w_x)
    );

    alu_fwd_mux #(.W(W), .RA(RA)) u_fwd_y (
        .i_src      (id_rt),
        .i_rf_data  (id_rt_data),
        .i_mem_we   (mem_we),
        .i_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .i_wb_we    (wb_we),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_fwd      (w_rt_fwd)
    );

    assign w_y = id_alusrc ? id_imm : w_rt_fwd;

    // Unknown ops still issue as AND with the illegal flag so EX can trap.
    always_comb begin
        w_opcode  = ALU_AND;
        w_illegal = 1'b0;
        unique case (id_aluop)
            AOP_ADD: w_opcode = ALU_ADD;
            AOP_SUB: w_opcode = ALU_SUB;
            AOP_RTYPE: begin
                case (id_funct)
                    FN_ADD:  w_opcode = ALU_ADD;
                    FN_SUB:  w_opcode = ALU_SUB;
                    FN_AND:  w_opcode = ALU_AND;
                    FN_OR:   w_opcode = ALU_OR;
                    FN_SLT:  w_opcode = ALU_SLT;
                    FN_NOR:  w_opcode = ALU_NOR;
                    default: w_illegal = 1'b1;
                endcase
            end
            AOP_ILL: w_illegal = 1'b1;
        endcase
    end

    assign id_ready = ~r_valid | ex_ready;
    assign w_load   = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_cin   <= 1'b0;
            r_op    <= ALU_AND;
            r_rd    <= '0;
            r_ill   <= 1'b0;
            r_stall <= '0;
        end else begin
            if (r_valid && !ex_ready && (r_stall != {CNT_W{1'b1}}))
                r_stall <= r_stall + CNT_W'(1);
            if (flush) begin
                r_valid <= 1'b0;
                r_ill   <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_x     <= w_x;
                r_y     <= w_y;
                r_cin   <= 1'b0;
                r_op    <= w_opcode;
                r_rd    <= id_rd;
                r_ill   <= w_illegal;
            end else if (ex_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ex_valid   = r_valid;
    assign alu_x      = r_x;
    assign alu_y      = r_y;
    assign alu_cin    = r_cin;
    assign alu_opcode = r_op;
    assign ex_rd      = r_rd;
    assign ex_illegal = r_ill;
    assign stall_cnt  = r_stall;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed issues push expected ALU
// inputs, a monitor pops and compares on each EX-side transfer.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        mem_we;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] alu_x, alu_y;
    logic        alu_cin;
    logic [3:0]  alu_opcode;
    logic [2:0]  ex_rd;
    logic        ex_illegal;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  op;
        logic        ill;
        logic [2:0]  rd;
    } exp_t;

    exp_t q[$];

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_aluop   (id_aluop),
        .id_funct   (id_funct),
        .id_alusrc  (id_alusrc),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_cin    (alu_cin),
        .alu_opcode (alu_opcode),
        .ex_rd      (ex_rd),
        .ex_illegal (ex_illegal),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic set_fwd(input logic mwe, input logic [2:0] mrd,
                           input logic [15:0] md, input logic wwe,
                           input logic [2:0] wrd, input logic [15:0] wd);
        mem_we = mwe; mem_rd = mrd; mem_data = md;
        wb_we = wwe; wb_rd = wrd; wb_data = wd;
    endtask

    task automatic issue(input logic [1:0] aop, input logic [5:0] fn,
                         input logic asrc, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input logic [15:0] rsd, input logic [15:0] rtd,
                         input logic [15:0] imm, input logic [15:0] ex,
                         input logic [15:0] ey, input logic [3:0] eop,
                         input logic eill);
        bit ok;
        exp_t e;
        id_aluop = aop; id_funct = fn; id_alusrc = asrc;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (id_ready && !flush) begin
                e.x = ex; e.y = ey; e.op = eop; e.ill = eill; e.rd = rd;
                q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        id_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no id_ready required handshake");
        end
    endtask

    // Monitor: every accepted EX transfer must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ex_valid && ex_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_op: got ex_valid=1 required none");
                end else begin
                    e = q.pop_front();
                    chk("alu_x", 32'(alu_x), 32'(e.x));
                    chk("alu_y", 32'(alu_y), 32'(e.y));
                    chk("alu_opcode", 32'(alu_opcode), 32'(e.op));
                    chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
                    chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                    chk("alu_cin", 32'(alu_cin), 32'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_aluop = 2'b00; id_funct = 6'h0;
        id_alusrc = 1'b0; id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd0;
        id_rs_data = 16'h0; id_rt_data = 16'h0; id_imm = 16'h0;
        flush = 1'b0; ex_ready = 1'b1;
        set_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'(0));
        chk("rst_alu_x", 32'(alu_x), 32'(0));
        chk("rst_alu_y", 32'(alu_y), 32'(0));
        chk("rst_opcode", 32'(alu_opcode), 32'(0));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        chk("rst_id_ready", 32'(id_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Opcode decode, register-file operands
        issue(2'b10, 6'h20, 1'b0, 3'd1, 3'd2, 3'd4, 16'h0005, 16'h0005,
              16'h0, 16'h0005, 16'h0005, 4'b0010, 1'b0);
        issue(2'b10, 6'h25, 1'b0, 3'd1, 3'd2, 3'd1, 16'h00F0, 16'h0F0F,
              16'h0, 16'h00F0, 16'h0F0F, 4'b0001, 1'b0);
        issue(2'b10, 6'h2A, 1'b0, 3'd3, 3'd4, 3'd2, 16'h1234, 16'h4321,
              16'h0, 16'h1234, 16'h4321, 4'b0111, 1'b0);
        issue(2'b10, 6'h27, 1'b0, 3'd5, 3'd6, 3'd3, 16'hAAAA, 16'h5555,
              16'h0, 16'hAAAA, 16'h5555, 4'b1100, 1'b0);
        issue(2'b10, 6'h24, 1'b0, 3'd7, 3'd1, 3'd5, 16'hFF00, 16'h0FF0,
              16'h0, 16'hFF00, 16'h0FF0, 4'b0000, 1'b0);

        // Forwarding: MEM beats WB, WB-only, r0 never forwards
        set_fwd(1'b1, 3'd3, 16'h0008, 1'b1, 3'd3, 16'h0007);
        issue(2'b10, 6'h20, 1'b0, 3'd3, 3'd3, 3'd5, 16'h0003, 16'h0003,
              16'h0, 16'h0008, 16'h0008, 4'b0010, 1'b0);
        set_fwd(1'b0, 3'd5, 16'h0008, 1'b1, 3'd5, 16'h0007);
        issue(2'b10, 6'h20, 1'b0, 3'd5, 3'd6, 3'd1, 16'h0055, 16'h0066,
              16'h0, 16'h0007, 16'h0066, 4'b0010, 1'b0);
        set_fwd(1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 16'h5678);
        issue(2'b01, 6'h00, 1'b0, 3'd0, 3'd0, 3'd2, 16'hAAAA, 16'hBBBB,
              16'h0, 16'h0000, 16'h0000, 4'b0110, 1'b0);

        // Immediate path ignores a forwarding hit on rt
        set_fwd(1'b1, 3'd2, 16'h9999, 1'b0, 3'd0, 16'h0);
        issue(2'b00, 6'h00, 1'b1, 3'd1, 3'd2, 3'd3, 16'h000A, 16'h1111,
              16'hFFF8, 16'h000A, 16'hFFF8, 4'b0010, 1'b0);
        set_fwd(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        issue(2'b11, 6'h20, 1'b0, 3'd1, 3'd2, 3'd4, 16'h0001, 16'h0002,
              16'h0, 16'h0001, 16'h0002, 4'b0000, 1'b1);

        // Stall: three frozen cycles, then the waiting sub loads
        issue(2'b10, 6'h20, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h0022,
              16'h0, 16'h0011, 16'h0022, 4'b0010, 1'b0);
        ex_ready = 1'b0;
        id_aluop = 2'b10; id_funct = 6'h22; id_alusrc = 1'b0;
        id_rs = 3'd4; id_rt = 3'd5; id_rd = 3'd6;
        id_rs_data = 16'h0050; id_rt_data = 16'h0030;
        id_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_cnt_3", 32'(stall_cnt), 32'(3));
        chk("stall_id_ready", 32'(id_ready), 32'(0));
        chk("stall_ex_valid", 32'(ex_valid), 32'(1));
        chk("stall_hold_x", 32'(alu_x), 32'h0011);
        chk("stall_hold_y", 32'(alu_y), 32'h0022);
        chk("stall_hold_op", 32'(alu_opcode), 32'(4'b0010));
        ex_ready = 1'b1;
        issue(2'b10, 6'h22, 1'b0, 3'd4, 3'd5, 3'd6, 16'h0050, 16'h0030,
              16'h0, 16'h0050, 16'h0030, 4'b0110, 1'b0);
        chk("stall_cnt_kept", 32'(stall_cnt), 32'(3));

        // Illegal funct, then flush kills a simultaneous and-op offer
        issue(2'b10, 6'h3F, 1'b0, 3'd1, 3'd2, 3'd7, 16'h0101, 16'h0202,
              16'h0, 16'h0101, 16'h0202, 4'b0000, 1'b1);
        flush = 1'b1;
        id_aluop = 2'b10; id_funct = 6'h24; id_rd = 3'd2;
        id_valid = 1'b1;
        @(posedge clk); #1;
        chk("flush_ex_valid", 32'(ex_valid), 32'(0));
        chk("flush_ex_illegal", 32'(ex_illegal), 32'(0));
        flush = 1'b0;
        id_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush_no_and", 32'(ex_valid), 32'(0));

        // Asynchronous reset while an op is held
        ex_ready = 1'b0;
        issue(2'b10, 6'h20, 1'b0, 3'd1, 3'd2, 3'd7, 16'h00AB, 16'h00CD,
              16'h0, 16'h00AB, 16'h00CD, 4'b0010, 1'b0);
        @(posedge clk); #3;
        chk("pre_rst_valid", 32'(ex_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(ex_valid), 32'(0));
        chk("arst_alu_x", 32'(alu_x), 32'(0));
        chk("arst_alu_y", 32'(alu_y), 32'(0));
        chk("arst_ex_rd", 32'(ex_rd), 32'(0));
        chk("arst_stall_cnt", 32'(stall_cnt), 32'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stall counter saturates at all-ones
        issue(2'b00, 6'h00, 1'b0, 3'd1, 3'd2, 3'd1, 16'h0001, 16'h0002,
              16'h0, 16'h0001, 16'h0002, 4'b0010, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("stall_cnt_fffe", 32'(stall_cnt), 32'h0000FFFE);
        @(posedge clk); #1;
        chk("stall_cnt_ffff", 32'(stall_cnt), 32'h0000FFFF);
        @(posedge clk); #1;
        chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000FFFF);
        ex_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'(0));
        chk("drained", 32'(ex_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
